// File: rtl/pc_seq.sv
// Program-counter sequencer: boot delay, sequential fetch, trap/redirect/halt control
// and an accepted-fetch counter.
module pc_seq #(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] RESET_VEC   = 32'h0,
  parameter int unsigned STEP        = 4,
  parameter int unsigned BOOT_DELAY  = 1,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_rdy_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              halt_i,
  input  logic              resume_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic [31:0]       fetch_cnt_o,
  output logic [1:0]        dbg_state_o
);

  // Fetch handshake: pc_o is offered whenever ce_o is high; the fetch is taken
  // in any cycle where ce_o && fetch_rdy_i and no trap/redirect/halt outranks it.

  localparam logic [ADDR_W-1:0] RST_PC     = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);
  localparam logic [3:0]        BOOT_LAST  = 4'(BOOT_DELAY - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic              redirect_bad;
  logic [ADDR_W-1:0] trap_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 4'd0;
      pc_q        <= RST_PC;
      bad_addr_q  <= '0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pc_q        <= pc_d;
      bad_addr_q  <= bad_addr_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    bad_addr_d   = bad_addr_q;
    misalign_d   = 1'b0;
    fetch_cnt_d  = fetch_cnt_q;
    redirect_bad = ALIGN_CHECK && ((redirect_addr_i & ALIGN_MASK) != '0);
    trap_pc      = trap_vec_i & ~ALIGN_MASK;

    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (trap_i) begin
          pc_d = trap_pc;
        end else if (redirect_i) begin
          if (redirect_bad) begin
            bad_addr_d = redirect_addr_i;
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d = redirect_addr_i;
          end
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (fetch_rdy_i) begin
          pc_d        = pc_q + STEP_INC;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      ST_HALT: begin
        // A trap always wakes the core; a redirect only leaves HALT alongside resume.
        if (trap_i) begin
          pc_d    = trap_pc;
          state_d = ST_RUN;
        end else if (redirect_i) begin
          if (redirect_bad) begin
            bad_addr_d = redirect_addr_i;
            misalign_d = 1'b1;
          end else begin
            pc_d = redirect_addr_i;
            if (resume_i) state_d = ST_RUN;
          end
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign pc_o        = pc_q;
  assign ce_o        = (state_q == ST_RUN);
  assign misalign_o  = misalign_q;
  assign bad_addr_o  = bad_addr_q;
  assign fetch_cnt_o = fetch_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: a rule-level model checked every cycle on the default instance,
// plus directed literal checks, and a narrow 8-bit / long-boot instance.
module tb_pc_seq;

  localparam int unsigned STEP = 4;
  localparam int          BD   = 1;

  logic        clk;
  logic        rst;
  logic        fetch_rdy_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        trap_i;
  logic [31:0] trap_vec_i;
  logic        halt_i;
  logic        resume_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        misalign_o;
  logic [31:0] bad_addr_o;
  logic [31:0] fetch_cnt_o;
  logic [1:0]  dbg_state_o;

  logic [7:0]  s_pc;
  logic        s_ce;
  logic        s_mis;
  logic [7:0]  s_bad;
  logic [31:0] s_cnt;
  logic [1:0]  s_dbg;

  int errors;
  int checks;
  bit cmp_en;

  pc_seq u_dut (
    .clk(clk), .rst(rst), .fetch_rdy_i(fetch_rdy_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .trap_i(trap_i), .trap_vec_i(trap_vec_i),
    .halt_i(halt_i), .resume_i(resume_i),
    .pc_o(pc_o), .ce_o(ce_o), .misalign_o(misalign_o),
    .bad_addr_o(bad_addr_o), .fetch_cnt_o(fetch_cnt_o), .dbg_state_o(dbg_state_o)
  );

  pc_seq #(.ADDR_W(8), .RESET_VEC(32'h1F0), .STEP(4), .BOOT_DELAY(3)) u_small (
    .clk(clk), .rst(rst), .fetch_rdy_i(1'b1),
    .redirect_i(1'b0), .redirect_addr_i(8'h00),
    .trap_i(1'b0), .trap_vec_i(8'h00),
    .halt_i(1'b0), .resume_i(1'b0),
    .pc_o(s_pc), .ce_o(s_ce), .misalign_o(s_mis),
    .bad_addr_o(s_bad), .fetch_cnt_o(s_cnt), .dbg_state_o(s_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [31:0] m_pc, m_cnt, m_bad;
  logic        m_mis, m_halted;
  int          m_boot_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_cnt <= 32'd0; m_bad <= 32'h0; m_mis <= 1'b0;
      m_halted <= 1'b0; m_boot_left <= BD;
    end else begin
      m_mis <= 1'b0;
      if (m_boot_left > 0) begin
        m_boot_left <= m_boot_left - 1;
      end else if (trap_i) begin
        m_pc <= trap_vec_i - (trap_vec_i % STEP);
        m_halted <= 1'b0;
      end else if (redirect_i) begin
        if ((redirect_addr_i % STEP) != 0) begin
          m_bad <= redirect_addr_i; m_mis <= 1'b1; m_halted <= 1'b1;
        end else begin
          m_pc <= redirect_addr_i;
          if (resume_i) m_halted <= 1'b0;
        end
      end else if (!m_halted) begin
        if (halt_i) m_halted <= 1'b1;
        else if (fetch_rdy_i) begin
          m_pc <= m_pc + STEP; m_cnt <= m_cnt + 1;
        end
      end else if (resume_i) begin
        m_halted <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",  pc_o, m_pc);
      chk("model_ce",  {31'd0, ce_o}, {31'd0, (m_boot_left == 0) && !m_halted});
      chk("model_mis", {31'd0, misalign_o}, {31'd0, m_mis});
      chk("model_bad", bad_addr_o, m_bad);
      chk("model_cnt", fetch_cnt_o, m_cnt);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    redirect_i = 1'b0; trap_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; cmp_en = 1'b0;
    rst = 1'b0; fetch_rdy_i = 1'b0; redirect_addr_i = '0; trap_vec_i = '0;
    clear_events();
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_ce", {31'd0, ce_o}, 32'd0);
    chk("rst_cnt", fetch_cnt_o, 32'd0);
    chk("rst_bad", bad_addr_o, 32'h0);
    chk("rst_small_pc", {24'd0, s_pc}, 32'hF0);
    cmp_en = 1'b1;
    step(); step();

    // Boot then sequential fetch
    rst = 1'b0; fetch_rdy_i = 1'b1;
    chk("boot_ce0", {31'd0, ce_o}, 32'd0);
    step(); chk("first_ce", {31'd0, ce_o}, 32'd1); chk("first_pc", pc_o, 32'h0);
    step(); chk("seq_pc4", pc_o, 32'h4); chk("seq_cnt1", fetch_cnt_o, 32'd1);
    step(); chk("seq_pc8", pc_o, 32'h8); chk("seq_cnt2", fetch_cnt_o, 32'd2);
    step(); chk("seq_pcC", pc_o, 32'hC); chk("seq_cnt3", fetch_cnt_o, 32'd3);
    step(); chk("seq_pc10", pc_o, 32'h10);

    // Trap beats redirect; trap vector aligned down
    redirect_i = 1'b1; redirect_addr_i = 32'h100; trap_i = 1'b1; trap_vec_i = 32'h203;
    step(); clear_events();
    chk("trap_pc", pc_o, 32'h200); chk("trap_ce", {31'd0, ce_o}, 32'd1);
    chk("trap_cnt", fetch_cnt_o, 32'd4);
    step(); chk("trap_next", pc_o, 32'h204);

    // Misaligned redirect -> HALT with one-cycle pulse
    redirect_i = 1'b1; redirect_addr_i = 32'h102;
    step(); clear_events();
    chk("mis_pc", pc_o, 32'h204); chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_bad", bad_addr_o, 32'h102); chk("mis_ce", {31'd0, ce_o}, 32'd0);
    step(); chk("mis_end", {31'd0, misalign_o}, 32'd0); chk("mis_hold", pc_o, 32'h204);
    resume_i = 1'b1;
    step(); clear_events(); chk("resume_ce", {31'd0, ce_o}, 32'd1);
    step(); chk("resume_pc", pc_o, 32'h208); chk("resume_cnt", fetch_cnt_o, 32'd6);

    // Halt with ready high; ready toggling in HALT
    redirect_i = 1'b1; redirect_addr_i = 32'h40;
    step(); clear_events(); chk("redir_pc", pc_o, 32'h40);
    halt_i = 1'b1;
    step(); clear_events();
    chk("halt_pc", pc_o, 32'h40); chk("halt_cnt", fetch_cnt_o, 32'd6);
    chk("halt_ce", {31'd0, ce_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      fetch_rdy_i = ~fetch_rdy_i; halt_i = (i == 1);
      step();
    end
    clear_events(); fetch_rdy_i = 1'b1;
    chk("halt_toggle_pc", pc_o, 32'h40); chk("halt_toggle_cnt", fetch_cnt_o, 32'd6);

    // Redirect in HALT without and with resume; trap in HALT over resume
    redirect_i = 1'b1; redirect_addr_i = 32'h300;
    step(); clear_events();
    chk("hredir_pc", pc_o, 32'h300); chk("hredir_ce", {31'd0, ce_o}, 32'd0);
    redirect_i = 1'b1; redirect_addr_i = 32'h310; resume_i = 1'b1;
    step(); clear_events();
    chk("hredir_res_pc", pc_o, 32'h310); chk("hredir_res_ce", {31'd0, ce_o}, 32'd1);
    halt_i = 1'b1; step(); clear_events();
    trap_i = 1'b1; trap_vec_i = 32'h407; resume_i = 1'b1;
    step(); clear_events();
    chk("htrap_pc", pc_o, 32'h404); chk("htrap_ce", {31'd0, ce_o}, 32'd1);

    // Top-of-space wrap and idle hold
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC;
    step(); clear_events();
    step(); chk("wrap_pc", pc_o, 32'h0); chk("wrap_ce", {31'd0, ce_o}, 32'd1);
    fetch_rdy_i = 1'b0;
    step(); step(); chk("idle_pc", pc_o, 32'h0);

    // Asynchronous reset between edges
    redirect_i = 1'b1; redirect_addr_i = 32'h80;
    step(); clear_events(); chk("pre_rst_pc", pc_o, 32'h80);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc_o, 32'h0); chk("arst_ce", {31'd0, ce_o}, 32'd0);
    chk("arst_cnt", fetch_cnt_o, 32'd0); chk("arst_bad", bad_addr_o, 32'h0);
    chk("arst_small_pc", {24'd0, s_pc}, 32'hF0);
    step(); rst = 1'b0;

    // Narrow instance: boot delay of 3, then 8-bit wrap
    step(); chk("s_boot1", {31'd0, s_ce}, 32'd0);
    step(); chk("s_boot2", {31'd0, s_ce}, 32'd0);
    step(); chk("s_boot3", {31'd0, s_ce}, 32'd1); chk("s_pc0", {24'd0, s_pc}, 32'hF0);
    step(); step(); step(); chk("s_pcFC", {24'd0, s_pc}, 32'hFC);
    step(); chk("s_wrap", {24'd0, s_pc}, 32'h00); chk("s_wrap_ce", {31'd0, s_ce}, 32'd1);
    chk("s_cnt", s_cnt, 32'd4);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
